// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings for the forwarding / hazard controller: operand-select codes,
// wait-FSM state constants and the performance counter width.
package fwd_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_MC  = 2'b11;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] SB_WAIT = 1'b1;

    localparam int PERF_W = 32;

endpackage

// File: rtl/fwd_scoreboard.sv
// Register scoreboard for the out-of-band multi-cycle unit: per-register pend bits,
// outstanding-op counter with full flag, and combinational lookups for the ID stage.
module fwd_scoreboard
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int MC_MAX_OUT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      done,
    input  logic [REG_AW-1:0]         done_rd,
    input  logic [NUM_SRC*REG_AW-1:0] look_rs,
    input  logic [REG_AW-1:0]         look_rd,
    output logic [NUM_SRC-1:0]        rs_pend,
    output logic                      rd_pend,
    output logic                      full
);

    localparam int NREG  = 1 << REG_AW;
    localparam int CNT_W = $clog2(MC_MAX_OUT + 1);

    logic [NREG-1:0]  pend;
    logic [NREG-1:0]  pend_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Clear first so a same-cycle set on the same entry wins; x0 is never pending.
    always_comb begin
        pend_nxt = pend;
        if (done) begin
            pend_nxt[done_rd] = 1'b0;
        end
        if (issue && (issue_rd != '0)) begin
            pend_nxt[issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    assign full = (count == CNT_W'(MC_MAX_OUT));

    // Issue-while-full and done-while-empty leave the count where it is.
    always_comb begin
        count_nxt = count;
        if (issue && !done && !full) begin
            count_nxt = count + CNT_W'(1);
        end else if (done && !issue && (count != '0)) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            count <= '0;
        end else begin
            pend  <= pend_nxt;
            count <= count_nxt;
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_look
        assign rs_pend[k] = pend[look_rs[k*REG_AW +: REG_AW]];
    end

    assign rd_pend = pend[look_rd];

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding, load-use / scoreboard stall generation and scoreboard-wait
// watchdog. Optional perf counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 5,
    parameter int MC_MAX_OUT = 2,
    parameter int WD_LIMIT   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]        id_rs_use_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_regw_i,
    input  logic                      id_is_mc_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      ex_regw_i,
    input  logic                      ex_is_load_i,
    input  logic [REG_AW-1:0]         mem_rd_i,
    input  logic                      mem_regw_i,
    input  logic [REG_AW-1:0]         wb_rd_i,
    input  logic                      wb_regw_i,
    input  logic                      mc_issue_i,
    input  logic [REG_AW-1:0]         mc_issue_rd_i,
    input  logic                      mc_done_i,
    input  logic [REG_AW-1:0]         mc_done_rd_i,
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic                      mc_full_o,
    output logic                      wd_err_o
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]         perf_stall_cnt_o,
    output logic [PERF_W-1:0]         perf_fwd_cnt_o
`endif
);

    localparam int WC_W = $clog2(WD_LIMIT + 1);

    logic [NUM_SRC-1:0] rs_pend;
    logic [NUM_SRC-1:0] lu_hit;
    logic [NUM_SRC-1:0] raw_hit;
    logic               rd_pend;
    logic               load_use;
    logic               sb_raw;
    logic               sb_waw;
    logic               mc_struct;
    logic               sb_hold;
    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic [WC_W-1:0]    wait_cnt;
    logic [WC_W-1:0]    wait_cnt_nxt;

    fwd_scoreboard #(
        .NUM_SRC    (NUM_SRC),
        .REG_AW     (REG_AW),
        .MC_MAX_OUT (MC_MAX_OUT)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (mc_issue_i),
        .issue_rd (mc_issue_rd_i),
        .done     (mc_done_i),
        .done_rd  (mc_done_rd_i),
        .look_rs  (id_rs_i),
        .look_rd  (id_rd_i),
        .rs_pend  (rs_pend),
        .rd_pend  (rd_pend),
        .full     (mc_full_o)
    );

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_AW-1:0] ex_rs;
        logic [REG_AW-1:0] id_rs;
        logic              id_used;
        logic [1:0]        sel;

        assign ex_rs   = ex_rs_i[k*REG_AW +: REG_AW];
        assign id_rs   = id_rs_i[k*REG_AW +: REG_AW];
        assign id_used = id_rs_use_i[k] && (id_rs != '0);

        assign lu_hit[k]  = id_used && (id_rs == ex_rd_i);
        assign raw_hit[k] = id_used && rs_pend[k];

        // Later assignments override earlier ones: EX/MEM > mc bus > MEM/WB > regfile.
        always_comb begin
            sel = FWD_RF;
            if (wb_regw_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs)) begin
                sel = FWD_WB;
            end
            if (mc_done_i && (mc_done_rd_i != '0) && (mc_done_rd_i == ex_rs)) begin
                sel = FWD_MC;
            end
            if (mem_regw_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs)) begin
                sel = FWD_MEM;
            end
        end

        assign fwd_sel_o[2*k +: 2] = sel;
    end

    assign load_use  = id_valid_i && ex_is_load_i && ex_regw_i && (ex_rd_i != '0) && (|lu_hit);
    assign sb_raw    = id_valid_i && (|raw_hit);
    assign sb_waw    = id_valid_i && id_regw_i && (id_rd_i != '0) && rd_pend;
    assign mc_struct = id_valid_i && id_is_mc_i && mc_full_o;
    assign sb_hold   = sb_raw || sb_waw || mc_struct;

    assign stall_o  = load_use || sb_hold;
    assign bubble_o = stall_o;

    // Load-use never reaches the wait FSM; only scoreboard-related holds are timed.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        if (state == RUN) begin
            if (sb_hold) begin
                state_nxt    = SB_WAIT;
                wait_cnt_nxt = '0;
            end
        end else begin
            if (!sb_hold) begin
                state_nxt = RUN;
            end
            if (wait_cnt != WC_W'(WD_LIMIT)) begin
                wait_cnt_nxt = wait_cnt + WC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            wd_err_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (wait_cnt_nxt == WC_W'(WD_LIMIT)) begin
                wd_err_o <= 1'b1;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic fwd_any;

    assign fwd_any = |fwd_sel_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
            perf_fwd_cnt_o   <= '0;
        end else begin
            perf_stall_cnt_o <= perf_stall_cnt_o + PERF_W'(stall_o);
            perf_fwd_cnt_o   <= perf_fwd_cnt_o + PERF_W'(fwd_any);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard-driven bench for fwd_hazard_ctrl: expectations are queued as each
// cycle's stimulus is driven and compared on the following falling edge.
module tb_fwd_hazard_ctrl;
    import fwd_hazard_ctrl_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int REG_AW  = 5;

    localparam int O_SEL    = 0;
    localparam int O_STALL  = 1;
    localparam int O_BUBBLE = 2;
    localparam int O_FULL   = 3;
    localparam int O_WD     = 4;

    logic                      clk;
    logic                      rst_n;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_use;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_regw;
    logic                      id_is_mc;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_regw;
    logic                      ex_is_load;
    logic [REG_AW-1:0]         mem_rd;
    logic                      mem_regw;
    logic [REG_AW-1:0]         wb_rd;
    logic                      wb_regw;
    logic                      mc_issue;
    logic [REG_AW-1:0]         mc_issue_rd;
    logic                      mc_done;
    logic [REG_AW-1:0]         mc_done_rd;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall;
    logic                      bubble;
    logic                      mc_full;
    logic                      wd_err;
`ifdef FWD_HAZARD_PERF_EN
    logic [PERF_W-1:0]         perf_stall_cnt;
    logic [PERF_W-1:0]         perf_fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int          exp_what_q[$];
    logic [31:0] exp_val_q[$];
    string       exp_tag_q[$];

    fwd_hazard_ctrl #(
        .NUM_SRC    (NUM_SRC),
        .REG_AW     (REG_AW),
        .MC_MAX_OUT (2),
        .WD_LIMIT   (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rs_use_i   (id_rs_use),
        .id_rd_i       (id_rd),
        .id_regw_i     (id_regw),
        .id_is_mc_i    (id_is_mc),
        .ex_rs_i       (ex_rs),
        .ex_rd_i       (ex_rd),
        .ex_regw_i     (ex_regw),
        .ex_is_load_i  (ex_is_load),
        .mem_rd_i      (mem_rd),
        .mem_regw_i    (mem_regw),
        .wb_rd_i       (wb_rd),
        .wb_regw_i     (wb_regw),
        .mc_issue_i    (mc_issue),
        .mc_issue_rd_i (mc_issue_rd),
        .mc_done_i     (mc_done),
        .mc_done_rd_i  (mc_done_rd),
        .fwd_sel_o     (fwd_sel),
        .stall_o       (stall),
        .bubble_o      (bubble),
        .mc_full_o     (mc_full),
        .wd_err_o      (wd_err)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_fwd_cnt_o   (perf_fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int what);
        case (what)
            O_SEL:    return 32'(fwd_sel);
            O_STALL:  return 32'(stall);
            O_BUBBLE: return 32'(bubble);
            O_FULL:   return 32'(mc_full);
            default:  return 32'(wd_err);
        endcase
    endfunction

    task automatic expect_out(input int what, input logic [31:0] val, input string tag);
        exp_what_q.push_back(what);
        exp_val_q.push_back(val);
        exp_tag_q.push_back(tag);
    endtask

    task automatic cycle();
        @(negedge clk);
        while (exp_what_q.size() > 0) begin
            int          w;
            logic [31:0] v;
            string       t;
            w = exp_what_q.pop_front();
            v = exp_val_q.pop_front();
            t = exp_tag_q.pop_front();
            check(t, observe(w), v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rs_use   = '0;
        id_rd       = '0;
        id_regw     = 1'b0;
        id_is_mc    = 1'b0;
        ex_rs       = '0;
        ex_rd       = '0;
        ex_regw     = 1'b0;
        ex_is_load  = 1'b0;
        mem_rd      = '0;
        mem_regw    = 1'b0;
        wb_rd       = '0;
        wb_regw     = 1'b0;
        mc_issue    = 1'b0;
        mc_issue_rd = '0;
        mc_done     = 1'b0;
        mc_done_rd  = '0;
    endtask

    function automatic logic [NUM_SRC*REG_AW-1:0] pack2(input logic [REG_AW-1:0] s1,
                                                        input logic [REG_AW-1:0] s0);
        return {s1, s0};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        #1;
        // Reset state, plus forwarding still live while reset is held.
        mem_rd = 5'd5; mem_regw = 1'b1; ex_rs = pack2(5'd0, 5'd5);
        expect_out(O_SEL, 32'h2, "rst_fwd_live");
        expect_out(O_FULL, 32'h0, "rst_full");
        expect_out(O_WD, 32'h0, "rst_wd");
        expect_out(O_STALL, 32'h0, "rst_stall");
        cycle();
        rst_n = 1'b1;

        // Forwarding priority
        set_idle();
        mem_rd = 5'd5; mem_regw = 1'b1; wb_rd = 5'd5; wb_regw = 1'b1; ex_rs = pack2(5'd0, 5'd5);
        expect_out(O_SEL, 32'h2, "fwd_mem_over_wb");
        cycle();
        mem_rd = 5'd0; wb_rd = 5'd0;
        expect_out(O_SEL, 32'h0, "fwd_rd_zero");
        cycle();
        set_idle();
        wb_rd = 5'd6; wb_regw = 1'b1; ex_rs = pack2(5'd6, 5'd0);
        expect_out(O_SEL, 32'h4, "fwd_wb_src1");
        cycle();
        mc_done = 1'b1; mc_done_rd = 5'd6;
        expect_out(O_SEL, 32'hC, "fwd_mc_over_wb");
        cycle();
        mem_rd = 5'd6; mem_regw = 1'b1;
        expect_out(O_SEL, 32'h8, "fwd_mem_over_mc");
        cycle();

        // Load-use
        set_idle();
        id_valid = 1'b1; id_rs = pack2(5'd7, 5'd0); id_rs_use = 2'b10;
        ex_is_load = 1'b1; ex_regw = 1'b1; ex_rd = 5'd7;
        expect_out(O_STALL, 32'h1, "lu_stall");
        expect_out(O_BUBBLE, 32'h1, "lu_bubble");
        cycle();
        ex_is_load = 1'b0; ex_regw = 1'b0; ex_rd = 5'd0;
        ex_rs = pack2(5'd7, 5'd0); wb_rd = 5'd7; wb_regw = 1'b1;
        expect_out(O_STALL, 32'h0, "lu_one_cycle");
        expect_out(O_SEL, 32'h4, "lu_fwd_wb");
        cycle();
        set_idle();
        id_valid = 1'b1; id_rs = pack2(5'd7, 5'd0); id_rs_use = 2'b01;
        ex_is_load = 1'b1; ex_regw = 1'b1; ex_rd = 5'd7;
        expect_out(O_STALL, 32'h0, "lu_unused_src");
        cycle();

        // Scoreboard RAW / WAW
        set_idle();
        mc_issue = 1'b1; mc_issue_rd = 5'd9;
        id_valid = 1'b1; id_rs = pack2(5'd0, 5'd9); id_rs_use = 2'b01;
        expect_out(O_STALL, 32'h0, "raw_issue_cycle");
        cycle();
        mc_issue = 1'b0;
        expect_out(O_STALL, 32'h1, "raw_stall");
        expect_out(O_BUBBLE, 32'h1, "raw_bubble");
        cycle();
        id_rs_use = 2'b00; id_regw = 1'b1; id_rd = 5'd9;
        expect_out(O_STALL, 32'h1, "waw_stall");
        cycle();
        id_rs_use = 2'b01; id_regw = 1'b0; id_rd = 5'd0;
        mc_done = 1'b1; mc_done_rd = 5'd9;
        expect_out(O_STALL, 32'h1, "raw_done_same_cycle");
        cycle();
        mc_done = 1'b0;
        expect_out(O_STALL, 32'h0, "raw_released");
        cycle();

        // Structural: outstanding limit
        set_idle();
        mc_issue = 1'b1; mc_issue_rd = 5'd10;
        expect_out(O_FULL, 32'h0, "st_full0");
        cycle();
        mc_issue_rd = 5'd11;
        expect_out(O_FULL, 32'h0, "st_full1");
        cycle();
        mc_issue = 1'b0; id_valid = 1'b1; id_is_mc = 1'b1;
        expect_out(O_FULL, 32'h1, "st_full2");
        expect_out(O_STALL, 32'h1, "st_stall");
        cycle();
        mc_done = 1'b1; mc_done_rd = 5'd10;
        expect_out(O_STALL, 32'h1, "st_done_same_cycle");
        cycle();
        mc_done = 1'b0;
        expect_out(O_FULL, 32'h0, "st_full_drop");
        expect_out(O_STALL, 32'h0, "st_stall_drop");
        cycle();
        set_idle();
        mc_done = 1'b1; mc_done_rd = 5'd11;
        cycle();

        // Counter saturation at both ends
        set_idle();
        mc_done = 1'b1;
        cycle();
        mc_done = 1'b0; mc_issue = 1'b1;
        cycle();
        expect_out(O_FULL, 32'h0, "sat_one");
        cycle();
        expect_out(O_FULL, 32'h1, "sat_underflow");
        cycle();
        mc_issue = 1'b0; mc_done = 1'b1;
        expect_out(O_FULL, 32'h1, "sat_overflow_hold");
        cycle();
        expect_out(O_FULL, 32'h0, "sat_overflow");
        cycle();
        mc_done = 1'b0;

        // Simultaneous set/clear on x4
        set_idle();
        mc_issue = 1'b1; mc_issue_rd = 5'd4;
        cycle();
        mc_done = 1'b1; mc_done_rd = 5'd4;
        cycle();
        set_idle();
        id_valid = 1'b1; id_rs = pack2(5'd4, 5'd0); id_rs_use = 2'b10;
        expect_out(O_STALL, 32'h1, "same_rd_pend_kept");
        expect_out(O_FULL, 32'h0, "same_rd_count");
        cycle();
        mc_issue = 1'b1; mc_issue_rd = 5'd0;
        cycle();
        mc_issue = 1'b0;
        expect_out(O_FULL, 32'h1, "same_rd_count_plus1");
        cycle();
        set_idle();
        mc_done = 1'b1; mc_done_rd = 5'd4;
        cycle();
        mc_done_rd = 5'd0;
        cycle();

        // Watchdog
        set_idle();
        mc_issue = 1'b1; mc_issue_rd = 5'd3;
        cycle();
        mc_issue = 1'b0;
        id_valid = 1'b1; id_rs = pack2(5'd0, 5'd3); id_rs_use = 2'b01;
        for (int i = 0; i < 80; i++) begin
            if (i == 0 || i == 79) expect_out(O_STALL, 32'h1, "wd_stall");
            if (i == 40) expect_out(O_WD, 32'h0, "wd_early");
            if (i == 79) expect_out(O_WD, 32'h1, "wd_fired");
            cycle();
        end
        set_idle();
        expect_out(O_STALL, 32'h0, "wd_stall_clear");
        expect_out(O_WD, 32'h1, "wd_sticky");
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        check("wd_async_clr", 32'(wd_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        id_valid = 1'b1; id_rs = pack2(5'd0, 5'd3); id_rs_use = 2'b01;
        expect_out(O_STALL, 32'h0, "rst_pend_dropped");
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the pipelined RISC-V core, covering NUM_SRC source operands per instruction. It combines three functions:
- combinational EX-stage operand forwarding;
- load-use stall detection;
- a register scoreboard for a variable-latency multi-cycle unit (divider/multiplier) that writes back out of band, with a watchdog on scoreboard waits.

It sits beside the ID/EX pipeline register and drives the EX operand muxes and the IF/ID stall / ID/EX bubble controls.

## Interface
- NUM_SRC, 2: source operands per instruction.
- REG_AW, 5: register address width; the scoreboard has 2^REG_AW entries.
- MC_MAX_OUT, 2: maximum outstanding multi-cycle operations.
- WD_LIMIT, 64: scoreboard-wait cycles before the watchdog error fires.

Ports (clock and reset first):
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  valid instruction in ID.
- id_rs_i  in  NUM_SRC*REG_AW  ID source addresses; source k occupies bits [k*REG_AW +: REG_AW].
- id_rs_use_i  in  NUM_SRC  per-source "operand actually read".
- id_rd_i  in  REG_AW  ID destination.
- id_regw_i  in  1  ID instruction writes id_rd_i.
- id_is_mc_i  in  1  ID instruction issues to the multi-cycle unit.
- ex_rs_i  in  NUM_SRC*REG_AW  ID/EX source addresses.
- ex_rd_i  in  REG_AW  ID/EX destination.
- ex_regw_i  in  1  ID/EX write enable.
- ex_is_load_i  in  1  ID/EX instruction is a load.
- mem_rd_i  in  REG_AW  EX/MEM destination.
- mem_regw_i  in  1  EX/MEM write enable.
- wb_rd_i  in  REG_AW  MEM/WB destination.
- wb_regw_i  in  1  MEM/WB write enable.
- mc_issue_i  in  1  multi-cycle op accepted this cycle.
- mc_issue_rd_i  in  REG_AW  its destination.
- mc_done_i  in  1  multi-cycle result on the result bus this cycle.
- mc_done_rd_i  in  REG_AW  its destination.
- fwd_sel_o  out  2*NUM_SRC  per-source select: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 multi-cycle result bus.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  insert NOP into ID/EX.
- mc_full_o  out  1  outstanding count equals MC_MAX_OUT.
- wd_err_o  out  1  sticky watchdog error.

## Operation

Forwarding (combinational, per source k):
- Candidate sources are EX/MEM, the mc result bus, and MEM/WB. A candidate qualifies only when its write/valid is set, its rd != 0, and its rd == ex_rs[k].
- Priority: EX/MEM (10) > mc result bus, when mc_done_i (11) > MEM/WB (01) > regfile (00).

Hazards (combinational, gated by id_valid_i; a source counts only when id_rs_use_i[k]=1 and id_rs[k] != 0):
- load_use: ex_is_load_i & ex_regw_i & ex_rd_i != 0 & ex_rd_i == a used ID source.
- sb_raw: the pend bit of a used ID source is set.
- sb_waw: id_regw_i & id_rd_i != 0 & pend[id_rd_i] set.
- mc_struct: id_is_mc_i & mc_full_o.

Outputs: stall_o = bubble_o = load_use | sb_raw | sb_waw | mc_struct.

Scoreboard:
- pend is a 2^REG_AW-bit register.
- Set pend[mc_issue_rd_i] on mc_issue_i when the rd is nonzero.
- Clear pend[mc_done_rd_i] on mc_done_i.
- If set and clear hit the same entry in the same cycle, set wins.
- pend[0] is always 0.
- The outstanding counter increments on issue and decrements on done; both in one cycle leaves it unchanged. An issue while full, or a done while zero, saturates the counter and leaves it unchanged.

Wait FSM:
- RUN → SB_WAIT when (sb_raw | sb_waw | mc_struct) is true.
- SB_WAIT → RUN when all three are false.
- Entering SB_WAIT clears the wait counter; each cycle in SB_WAIT increments it.
- When the counter reaches WD_LIMIT, wd_err_o sets and stays set until reset. The counter saturates at WD_LIMIT.
- load_use never enters SB_WAIT.

## Timing
- Reset values: pend=0, count=0, FSM=RUN, wait counter=0, wd_err_o=0, perf counters=0.
- While reset is asserted, the combinational outputs still follow their inputs.
- fwd_sel_o, stall_o, bubble_o: zero-cycle latency (combinational).
- A pend set is visible to ID on the cycle after mc_issue_i.
- A same-cycle mc_done_i does not clear the stall for that cycle. The reader leaves ID on the following cycle and, in EX, picks the value up from the regfile.
- A load-use stall lasts exactly 1 cycle. The next cycle, the load is in MEM/WB and is forwarded with 01.
- Reset mid-wait: the FSM returns asynchronously to RUN and all pending entries are dropped.

## Configuration
- FWD_HAZARD_PERF_EN defined: adds output ports perf_stall_cnt_o (32) and perf_fwd_cnt_o (32).
  - perf_stall_cnt_o increments each cycle stall_o=1.
  - perf_fwd_cnt_o increments each cycle any fwd_sel_o field != 00.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package: the fwd_sel encodings (FWD_RF, FWD_WB, FWD_MEM, FWD_MC), the FSM state enum (RUN, SB_WAIT), and the perf counter width.
- Sub-module fwd_scoreboard holds pend, the outstanding counter, mc_full_o, and the lookup ports. The top level holds forwarding, hazard logic, the FSM, the watchdog, and the perf counters.

## Test plan
- EX/MEM rd=5 with regw, MEM/WB rd=5 with regw, ex_rs0=5 → fwd_sel[1:0]=10. Repeat with rd=0 on both → 00.
- Load in EX with rd=7, ID rs1=7 used → stall_o=bubble_o=1 for one cycle. Next cycle the ex_rs now matches wb_rd=7 → sel 01.
- mc_issue rd=9; ID reads x9 the next cycle → stall until the cycle after mc_done rd=9; FSM RUN→SB_WAIT→RUN.
- Two issues with MC_MAX_OUT=2, then ID mc op → mc_full_o=1 and stall. A done arrives → stall drops the next cycle.
- Pending x3 never completes → wd_err_o rises after 64 SB_WAIT cycles and stays 1 after the stall clears. Assert rst_n=0 → it clears asynchronously.
- Simultaneous mc_issue rd=4 and mc_done rd=4 → pend[4] remains 1 and the count is unchanged.
